// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters (round-robin), returns tagged results; optional WAIT watchdog under DIV_ARB_TIMEOUT_EN.
// Latency: accept at T -> resp_valid at T+1 for a zero divisor, at T+4 or later otherwise (divider start pulse at T+1, drdy blanked at T+2).
// Backpressure: one operation in flight; req*_ready stays low until the response handshakes, and the response holds while resp_ready is low.
module div_arbiter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_signctl,
  input  logic             req0_rem,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_signctl,
  input  logic             req1_rem,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_dbz,
  output logic             resp_timeout,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_signctl,
  output logic             div_rem,
  input  logic [WIDTH-1:0] div_dout,
  input  logic             div_drdy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             ptr;      // requester preferred when both are valid
  logic             blank;    // high during the first WAIT cycle, drdy is not trusted yet
  logic             gnt0, gnt1, accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_s, sel_r, sel_id;
  logic             drdy_ok;
  logic             to_hit;

  // Round-robin grant, only offered while idle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !ptr)) gnt0 = 1'b1;
      else if (req1_valid)                      gnt1 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign sel_id     = gnt1;
  assign sel_a      = gnt1 ? req1_a       : req0_a;
  assign sel_b      = gnt1 ? req1_b       : req0_b;
  assign sel_s      = gnt1 ? req1_signctl : req0_signctl;
  assign sel_r      = gnt1 ? req1_rem     : req0_rem;
  assign drdy_ok    = (state == WAIT) && !blank && div_drdy;

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    div_start  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (sel_b == '0) ? RESP : START;
      end
      START: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (drdy_ok || to_hit) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Operand capture, arbitration pointer and response payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= 1'b0;
      blank       <= 1'b0;
      div_a       <= '0;
      div_b       <= '0;
      div_signctl <= 1'b0;
      div_rem     <= 1'b0;
      resp_id     <= 1'b0;
      resp_data   <= '0;
      resp_dbz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr         <= !sel_id;
            div_a       <= sel_a;
            div_b       <= sel_b;
            div_signctl <= sel_s;
            div_rem     <= sel_r;
            resp_id     <= sel_id;
            if (sel_b == '0) begin
              // Zero divisor is answered locally; the divider is never started
              resp_dbz  <= 1'b1;
              resp_data <= sel_r ? sel_a : '1;
            end
          end
        end
        START: blank <= 1'b1;
        WAIT: begin
          blank <= 1'b0;
          if (drdy_ok)     resp_data <= div_dout;
          else if (to_hit) resp_data <= '0;
        end
        RESP: begin
          if (resp_ready) resp_dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        to_flag;

  // Expiry on the WAIT cycle whose count reaches the limit; a valid drdy in the same cycle wins
  assign to_hit       = (state == WAIT) && !drdy_ok && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign resp_timeout = to_flag;

  // Watchdog counter over WAIT cycles and sticky timeout flag for the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == START)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 16'd1;
      if (to_hit)                              to_flag <= 1'b1;
      else if ((state == RESP) && resp_ready)  to_flag <= 1'b0;
    end
  end
`else
  assign to_hit       = 1'b0;
  assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a bench-side divider model and a per-cycle reference model.
// Latency: n/a.
// Backpressure: resp_ready is driven by the stimulus to exercise response stalls.
module tb_div_arbiter;
  localparam int W     = 32;
  localparam int TB_TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid, req0_ready, req0_signctl, req0_rem;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_signctl, req1_rem;
  logic [W-1:0] req1_a, req1_b;
  logic         resp_valid, resp_ready, resp_id, resp_dbz, resp_timeout;
  logic [W-1:0] resp_data;
  logic         div_start, div_signctl, div_rem;
  logic [W-1:0] div_a, div_b;
  logic [W-1:0] div_dout = '0;
  logic         div_drdy = 1'b0;

  div_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_signctl(req0_signctl), .req0_rem(req0_rem),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_signctl(req1_signctl), .req1_rem(req1_rem),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_dbz(resp_dbz), .resp_timeout(resp_timeout),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_signctl(div_signctl), .div_rem(div_rem),
    .div_dout(div_dout), .div_drdy(div_drdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference arithmetic: what the response must carry for given operands
  function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic r);
    if (b == 0) return r ? a : 32'hFFFF_FFFF;
    if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return r ? (a % b) : (a / b);
  endfunction

  // External divider: drdy rises in cycle start+1+dly and stays high until the next start
  int dly       = 0;
  bit never_rdy = 0;
  bit dbusy     = 0;
  int dcnt      = 0;
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      dbusy    = 0;
      div_drdy = 1'b0;
    end else if (div_start) begin
      dbusy    = 1;
      dcnt     = dly;
      div_drdy = 1'b0;
      div_dout = div_ref(div_a, div_b, div_signctl, div_rem);
    end else if (dbusy && !never_rdy) begin
      if (dcnt == 0) div_drdy = 1'b1;
      else           dcnt--;
    end
  end

  // Reference model state: one outstanding operation, last granted requester
  bit           pend      = 0;
  bit           last_gnt  = 1;
  int           acc_cyc   = 0;
  int           due       = -1;
  bit           e_id, e_dbz, e_to;
  logic [31:0]  e_data;
  logic [31:0]  op_a, op_b;
  bit           op_s, op_r;
  int           start_cnt = 0;
  int           grant_log[$];
  int           last_acc_cyc = 0;
  int           last_hs_cyc  = 0;
  logic [31:0]  cap_data;
  bit           cap_id, cap_dbz, cap_to;
  int           cap_lat;

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    bit er0, er1, eds, erv, gid;
    if (!rst) begin
      pend     = 0;
      last_gnt = 1;
      due      = -1;
    end else begin
      er0 = 0;
      er1 = 0;
      if (!pend) begin
        if (req0_valid && req1_valid) begin
          er0 = (last_gnt == 1);
          er1 = (last_gnt == 0);
        end else begin
          er0 = req0_valid;
          er1 = req1_valid;
        end
        chk("idle_dbz_clear", resp_dbz, 0);
        chk("idle_timeout_clear", resp_timeout, 0);
      end
      chk("req0_ready", req0_ready, er0);
      chk("req1_ready", req1_ready, er1);
      chk("ready_onehot", req0_ready & req1_ready, 0);

      eds = pend && !e_dbz && (cyc == acc_cyc + 1);
      chk("div_start", div_start, eds);
      if (div_start) begin
        start_cnt++;
        chk("div_a", div_a, op_a);
        chk("div_b", div_b, op_b);
        chk("div_signctl", div_signctl, op_s);
        chk("div_rem", div_rem, op_r);
      end

      if (pend && !e_dbz && due < 0) begin
        if (cyc >= acc_cyc + 3 && div_drdy) begin
          due    = cyc + 1;
          e_data = div_ref(op_a, op_b, op_s, op_r);
        end
`ifdef DIV_ARB_TIMEOUT_EN
        else if (cyc == acc_cyc + 1 + TB_TO) begin
          due    = cyc + 1;
          e_data = 0;
          e_to   = 1;
        end
`endif
      end

      erv = pend && (due >= 0) && (cyc >= due);
      chk("resp_valid", resp_valid, erv);
      if (resp_valid && erv) begin
        chk("resp_id", resp_id, e_id);
        chk("resp_data", resp_data, e_data);
        chk("resp_dbz", resp_dbz, e_dbz);
        chk("resp_timeout", resp_timeout, e_to);
        if (cyc == due) begin
          cap_data = resp_data;
          cap_id   = resp_id;
          cap_dbz  = resp_dbz;
          cap_to   = resp_timeout;
          cap_lat  = cyc - acc_cyc;
        end
      end

      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        gid       = req1_valid && req1_ready;
        pend      = 1;
        acc_cyc   = cyc;
        last_acc_cyc = cyc;
        op_a      = gid ? req1_a : req0_a;
        op_b      = gid ? req1_b : req0_b;
        op_s      = gid ? req1_signctl : req0_signctl;
        op_r      = gid ? req1_rem : req0_rem;
        e_id      = gid;
        e_dbz     = (op_b == 0);
        e_to      = 0;
        due       = e_dbz ? cyc + 1 : -1;
        e_data    = e_dbz ? div_ref(op_a, op_b, op_s, op_r) : 32'h0;
        last_gnt  = gid;
        start_cnt = 0;
        grant_log.push_back(int'(gid));
      end else if (pend && erv && resp_ready) begin
        pend        = 0;
        last_hs_cyc = cyc;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic do_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input bit r);
    bit done = 0;
    if (id == 0) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_signctl = s; req0_rem = r;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_signctl = s; req1_rem = r;
    end
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (id == 0 ? req0_ready : req1_ready) done = 1;
      @(posedge clk); #1;
    end
    chk("req_accepted", done, 1);
    if (id == 0) req0_valid = 0;
    else         req1_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (pend && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("op_completed", pend, 0);
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  logic [31:0] bd;
  bit          bi;
  int          n0, nbp;

  initial begin
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_signctl = 0; req0_rem = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_signctl = 0; req1_rem = 0;
    resp_ready = 1;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_resp_timeout", resp_timeout, 0);
    #20 rst = 1;

    // Unsigned quotient, slow divider: drdy in cycle T+16 -> resp at T+17
    sync(); dly = 14; do_req(0, 100, 7, 0, 0); wait_idle();
    chk("t1_id", cap_id, 0); chk("t1_data", cap_data, 14); chk("t1_dbz", cap_dbz, 0);
    chk("t1_lat", cap_lat, 17); chk("t1_starts", start_cnt, 1);

    // Remainder, drdy already high in the blanking cycle -> resp at T+4
    sync(); dly = 0; do_req(1, 100, 7, 0, 1); wait_idle();
    chk("t2_id", cap_id, 1); chk("t2_data", cap_data, 2); chk("t2_lat", cap_lat, 4);

    // Divide by zero, quotient then remainder
    sync(); do_req(0, 5, 0, 0, 0); wait_idle();
    chk("dbz_q_data", cap_data, 32'hFFFF_FFFF); chk("dbz_q_flag", cap_dbz, 1);
    chk("dbz_q_lat", cap_lat, 1); chk("dbz_q_starts", start_cnt, 0);
    sync(); do_req(0, 5, 0, 0, 1); wait_idle();
    chk("dbz_r_data", cap_data, 5); chk("dbz_r_starts", start_cnt, 0);

    // Signed remainder -100 % 7 = -2
    sync(); dly = 3; do_req(1, 32'hFFFF_FF9C, 7, 1, 1); wait_idle();
    chk("signed_rem", cap_data, 32'hFFFF_FFFE); chk("signed_lat", cap_lat, 6);

    // Both requesters continuously valid
    sync(); dly = 2; n0 = grant_log.size();
    fork
      begin do_req(0, 40, 5, 0, 0); do_req(0, 41, 5, 0, 1); end
      begin do_req(1, 42, 5, 0, 0); do_req(1, 43, 5, 0, 1); end
    join
    wait_idle();
    chk("rr_count", grant_log.size() - n0, 4);
    if (grant_log.size() >= n0 + 4) begin
      chk("rr_g0", grant_log[n0], 0);     chk("rr_g1", grant_log[n0 + 1], 1);
      chk("rr_g2", grant_log[n0 + 2], 0); chk("rr_g3", grant_log[n0 + 3], 1);
    end

    // Response backpressure with req1 waiting
    sync(); dly = 1; resp_ready = 0; do_req(0, 20, 3, 0, 0);
    fork
      begin do_req(1, 21, 4, 0, 1); end
      begin
        nbp = 0;
        @(negedge clk);
        while (!resp_valid && nbp < 100) begin @(negedge clk); nbp++; end
        chk("bp_resp_seen", resp_valid, 1);
        bd = resp_data;
        bi = resp_id;
        repeat (10) begin
          @(negedge clk);
          chk("bp_valid", resp_valid, 1);
          chk("bp_data_stable", resp_data, bd);
          chk("bp_id_stable", resp_id, bi);
          chk("bp_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1 resp_ready = 1;
      end
    join
    chk("bp_data_val", bd, 6);
    chk("bp_grant_after_hs", last_acc_cyc - last_hs_cyc, 1);
    wait_idle();
    chk("bp_req1_data", cap_data, 1); chk("bp_req1_id", cap_id, 1);

    // Asynchronous reset in the middle of WAIT
    sync(); dly = 20; do_req(0, 1000, 3, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk("arst_resp_valid", resp_valid, 0); chk("arst_div_start", div_start, 0);
    chk("arst_div_a", div_a, 0);           chk("arst_div_b", div_b, 0);
    chk("arst_div_signctl", div_signctl, 0); chk("arst_div_rem", div_rem, 0);
    chk("arst_resp_data", resp_data, 0);   chk("arst_resp_id", resp_id, 0);
    chk("arst_resp_dbz", resp_dbz, 0);     chk("arst_resp_timeout", resp_timeout, 0);
    chk("arst_req0_ready", req0_ready, 0); chk("arst_req1_ready", req1_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // After reset the pointer favours requester 0 again
    dly = 1; n0 = grant_log.size();
    fork
      do_req(0, 9, 3, 0, 0);
      do_req(1, 9, 3, 0, 1);
    join
    wait_idle();
    chk("post_rst_count", grant_log.size() - n0, 2);
    if (grant_log.size() >= n0 + 2) begin
      chk("post_rst_g0", grant_log[n0], 0); chk("post_rst_g1", grant_log[n0 + 1], 1);
    end

`ifdef DIV_ARB_TIMEOUT_EN
    // Divider that never finishes
    sync(); never_rdy = 1; do_req(0, 50, 5, 0, 0); wait_idle();
    chk("to_flag", cap_to, 1); chk("to_data", cap_data, 0); chk("to_lat", cap_lat, TB_TO + 2);
    never_rdy = 0;
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
